// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers.
// Used by the key schedule and the cipher datapaths.
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned NK = 4;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef logic [31:0] word_t;
    typedef logic [127:0] block_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte per instance.
// Table is packed MSB-first: entry 0x00 sits in the top byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] sub
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    assign bit_idx = {~a, 3'b000};
    assign sub = SBOX[bit_idx +: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock into an
// 11-entry register file with a combinational random-access read port.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR   = 10,
    parameter int unsigned IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [127:0]    key_in,
    output logic            busy,
    output logic            done,
    output logic            keys_valid,
    output logic            rk_valid,
    output logic [IDXW-1:0] rk_idx,
    output logic [127:0]    rk_out,
    input  logic [IDXW-1:0] rd_idx,
    output logic [127:0]    rd_key
);

    localparam logic [IDXW-1:0] LAST = IDXW'(NR);

    ks_state_t       state_q, state_d;
    block_t          rk_q [0:NR];
    logic [IDXW-1:0] cnt_q;
    logic [IDXW-1:0] prev_idx;
    logic [7:0]      rcon_q;
    logic            load, step, last;

    block_t prev, next_key;
    word_t  w0, w1, w2, w3;
    word_t  rot, sub_w, t;
    word_t  n0, n1, n2, n3;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Previous round key comes from the array; index 15 only occurs in IDLE.
    assign prev_idx = cnt_q - 1'b1;
    assign prev = (prev_idx <= LAST) ? rk_q[prev_idx] : '0;

    assign w0 = prev[127:96];
    assign w1 = prev[95:64];
    assign w2 = prev[63:32];
    assign w3 = prev[31:0];

    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a   (rot[8*b +: 8]),
            .sub (sub_w[8*b +: 8])
        );
    end

    assign t  = sub_w ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk_valid   <= 1'b0;
            rk_idx     <= '0;
            rk_out     <= '0;
            cnt_q      <= '0;
            rcon_q     <= RCON_INIT;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            if (load) begin
                rk_q[0]    <= key_in;
                rk_out     <= key_in;
                rk_idx     <= '0;
                rk_valid   <= 1'b1;
                cnt_q      <= IDXW'(1);
                rcon_q     <= RCON_INIT;
                busy       <= 1'b1;
                keys_valid <= 1'b0;
            end else if (step) begin
                rk_q[cnt_q] <= next_key;
                rk_out      <= next_key;
                rk_idx      <= cnt_q;
                rk_valid    <= 1'b1;
                rcon_q      <= xtime(rcon_q);
                cnt_q       <= cnt_q + 1'b1;
                if (last) begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST) begin
            rd_key = rk_q[rd_idx];
        end
    end

endmodule
